// File: rtl/shifter_pkg.sv
// shifter_pkg: shared FSM encoding and stage constants for the iterative right shifter.
package shifter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  localparam int SHIFT_STAGES = 5;
  localparam logic [2:0] LAST_STAGE = 3'd4;
endpackage

// File: rtl/shift_right_stage.sv
// shift_right_stage: one reusable stage, shifts right by 2^stage with fill bits when enabled.
module shift_right_stage #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  input  logic [2:0]   stage,
  input  logic         enable,
  input  logic         fill,
  output logic [N-1:0] out
);
  logic [5:0] amt;
  assign amt = 6'd1 << stage;
  assign out = enable ? N'({{N{fill}}, in} >> amt) : in;
endmodule

// File: rtl/shift_right_iterative.sv
// shift_right_iterative: SRL/SRA resolving one shamt bit per clock through a single reused stage.
module shift_right_iterative
  import shifter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic                 arith,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         out,
  output logic                 out_valid,
  input  logic                 out_ready
);
  state_t                  state_q, state_d;
  logic [2:0]              stage_q, stage_d;
  logic [N-1:0]            work_q, work_d, stage_out;
  logic [SHIFT_STAGES-1:0] shamt_q, shamt_d;
  logic                    fill_q, fill_d, accept, shifting, stage_en;
  assign accept   = in_valid && in_ready;
  assign shifting = state_q == S_SHIFT;
  assign stage_en = |(shamt_q & (SHIFT_STAGES'(1) << stage_q));
  shift_right_stage #(.N(N)) u_stage (
    .in    (work_q),
    .stage (stage_q),
    .enable(stage_en),
    .fill  (fill_q),
    .out   (stage_out)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_SHIFT : S_IDLE;
      S_SHIFT: state_d = stage_q == LAST_STAGE ? S_DONE : S_SHIFT;
      S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == S_IDLE;
    out_valid = state_q == S_DONE;
    out       = work_q;
  end
  // Fill is latched at accept so later changes on in cannot leak into the result.
  always_comb begin
    work_d  = accept ? in : shifting ? stage_out : work_q;
    stage_d = accept ? 3'd0 : shifting ? stage_q + 3'd1 : stage_q;
    shamt_d = accept ? shamt : shamt_q;
    fill_d  = accept ? arith & in[N-1] : fill_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      stage_q <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      work_q  <= work_d;
      stage_q <= stage_d;
      shamt_q <= shamt_d;
      fill_q  <= fill_d;
    end
  end
endmodule

// File: tb/tb_shift_right_iterative.sv
// tb_shift_right_iterative: directed and randomized checks against a transaction-level model.
module tb_shift_right_iterative;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] in_d = '0, out;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  int vectors = 0, miscompares = 0;
  int cyc = 0, m_done_at = 0, m_acc_last = 0, m_acc_prev = 0, m_nacc = 0;
  bit m_busy = 0, m_zero = 1, started = 0;
  logic [31:0] m_res = '0;

  always #5 clk = ~clk;

  shift_right_iterative #(.N(32)) dut (
    .clk(clk), .rst(rst), .in(in_d), .shamt(shamt), .arith(arith),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [31:0] ref_shift(logic [31:0] v, logic [4:0] s, logic a);
    logic signed [31:0] sv;
    sv = $signed(v);
    if (a) return sv >>> s;
    return v >> s;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: accept when idle, result visible 5 edges later, leaves on out_ready.
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_busy = 0;
      m_zero = 1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1;
        m_done_at = cyc + 5;
        m_res = ref_shift(in_d, shamt, arith);
        m_zero = 0;
        m_acc_prev = m_acc_last;
        m_acc_last = cyc;
        m_nacc++;
      end
    end else if (cyc > m_done_at && out_ready) begin
      m_busy = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = m_busy && (cyc - 1 >= m_done_at);
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev || !m_busy) chk("out", out, m_zero ? 32'h0 : m_res);
    end
  end

  task automatic run_one(string name, logic [31:0] din, logic [4:0] s, logic a, logic [31:0] exp);
    int lat;
    @(negedge clk);
    in_d = din; shamt = s; arith = a; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 5);
    chk({name, "_out"}, out, exp);
  endtask

  task automatic wait_valid(string name);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, 32'(t < 20), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, t;
    repeat (2) @(negedge clk);
    chk("reset_out", out, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    chk("model_srl31", ref_shift(32'h8000_0000, 5'd31, 1'b0), 32'h0000_0001);
    chk("model_sra31", ref_shift(32'h8000_0001, 5'd31, 1'b1), 32'hFFFF_FFFF);
    chk("model_sra4", ref_shift(32'h7FFF_FFF0, 5'd4, 1'b1), 32'h07FF_FFFF);

    run_one("srl31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    run_one("sra4_neg", 32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
    run_one("sra4_pos", 32'h7FFF_FFF0, 5'd4, 1'b1, 32'h07FF_FFFF);
    run_one("shamt0", 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
    run_one("srl8", 32'h1234_5678, 5'd8, 1'b0, 32'h0012_3456);
    run_one("sra31_neg", 32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF);

    // Backpressure with a competing request held on the input.
    @(negedge clk);
    in_d = 32'h9ABC_DEF0; shamt = 5'd12; arith = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("bp_first");
    in_d = 32'h0F0F_0F0F; shamt = 5'd4; arith = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_out", out, 32'hFFF9_ABCD);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_taken", 32'(in_ready), 0);
    wait_valid("bp_second");
    chk("bp_second_out", out, 32'h00F0_F0F0);

    // Reset during stage 2 discards the transaction.
    @(negedge clk);
    @(negedge clk);
    in_d = 32'hCAFE_F00D; shamt = 5'd7; arith = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out", out, 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    run_one("after_rst", 32'hFFFF_0000, 5'd16, 1'b0, 32'h0000_FFFF);

    // Back-to-back with out_ready tied high: accepts every 7 cycles.
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_d = $urandom; shamt = 5'($urandom_range(0, 31)); arith = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      n0 = m_nacc;
      t = 0;
      while (m_nacc == n0 && t < 30) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_accept_timeout", 32'(t < 30), 1);
      if (i > 0) chk("b2b_spacing", m_acc_last - m_acc_prev, 7);
      in_d = $urandom; shamt = 5'($urandom_range(0, 31)); arith = 1'($urandom);
      if (i == 3) in_valid = 1'b0;
    end
    repeat (8) @(negedge clk);

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_d = $urandom;
      shamt = 5'($urandom_range(0, 31));
      arith = 1'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("final_in_ready", 32'(in_ready), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_right_iterative.md
# shift_right_iterative

Multi-cycle right shifter for the ALU datapath. It performs logical (SRL) and arithmetic (SRA) right shifts by resolving one shamt bit per clock: stage k conditionally shifts by 2^k. A valid/ready handshake sits on both input and output. It complements the single-cycle combinational left shifter and trades latency for a single reused stage instead of a 32-way mux.

## Interface
- N, 32: data width. Only N=32 is supported.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in  input  N  operand to shift
- shamt  input  $clog2(N)  shift amount, 0..31
- arith  input  1  1 = SRA (sign fill), 0 = SRL (zero fill)
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- out  output  N  shifted result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result

## Operation
- States:
  - S_IDLE: in_ready=1, out_valid=0.
  - S_SHIFT: in_ready=0, out_valid=0.
  - S_DONE: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready at an edge.
  - Latch in into the working register, shamt into shamt_r, and fill = arith & in[N-1].
  - Clear the stage counter to 0 and move to S_SHIFT.
- S_SHIFT, each edge:
  - If shamt_r[stage] is set, work = {{2^stage{fill}}, work[N-1:2^stage]}. Otherwise work is unchanged.
  - stage increments by 1.
  - The edge that applies stage 4 moves to S_DONE.
- All 5 stages always run. Latency does not depend on shamt, including shamt=0.
- S_DONE: out = work, held stable until out_valid && out_ready. That edge returns to S_IDLE.
- in_valid is ignored outside S_IDLE. Only one transaction is in flight; requests do not overlap.
- out = work in every state. Consumers qualify it with out_valid only.
- Width rules:
  - shamt is unsigned, 5 bits.
  - Fill comes only from the sign captured at accept, never from the live in.
  - SRA of a negative value by 31 gives all ones.
  - SRL by 31 gives {31'b0, in[31]}.

## Timing
- Reset, taking priority over everything:
  - state = S_IDLE, stage = 0, work = 0, shamt_r = 0, fill = 0.
  - Outputs: in_ready=1, out_valid=0, out=0.
- Reset mid-operation (S_SHIFT or S_DONE): the transaction is discarded with no partial result. The cycle after the rst edge shows reset values.
- Latency: accept at edge E0, out_valid=1 after edge E0+5.
- Throughput with out_ready tied high:
  - Result consumed at E0+6, back in S_IDLE.
  - Next accept at E0+7, so 1 result per 7 cycles.
- Backpressure: out_valid and out stay stable while out_ready=0, for any number of cycles.
- in_ready is a pure decode of state, with no combinational path from in_valid or out_ready.
- out_valid is a pure decode of state. out is registered.

## Structure
- Package shifter_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_SHIFT, S_DONE}
  - localparam SHIFT_STAGES = 5
  - localparam LAST_STAGE = 3'd4
- Sub-module shift_right_stage: combinational.
  - Inputs: in[N-1:0], stage[2:0], enable, fill.
  - Output: out = enable ? (in >> 2^stage) with fill bits : in.
  - Instantiated once and reused every cycle.
- Top level holds the FSM, stage counter, work, shamt_r and fill registers.

## Test plan
- SRL: in=0x8000_0000, shamt=31, arith=0 -> out=0x0000_0001, out_valid rises exactly 5 cycles after the accept edge.
- SRA: in=0x8000_0000, shamt=4, arith=1 -> out=0xF800_0000. Then in=0x7FFF_FFF0, shamt=4, arith=1 -> out=0x07FF_FFFF.
- shamt=0: in=0xDEAD_BEEF, arith=1 -> out=0xDEAD_BEEF with the same 5-cycle latency. Also in=0x1234_5678, shamt=8, arith=0 -> out=0x0012_3456.
- Backpressure: hold out_ready=0 for 3 cycles in S_DONE while driving in_valid=1 with new data -> out held constant, in_ready=0, new request not accepted until after the result is consumed.
- Reset mid-op: assert rst for 1 cycle during stage 2 -> next cycle out=0, out_valid=0, in_ready=1. A following request (in=0xFFFF_0000, shamt=16, arith=0) returns 0x0000_FFFF.
- Back-to-back: out_ready=1 constant, in_valid=1 with 4 random operands -> all results match the >> and >>> reference model, accepts spaced exactly 7 cycles apart.
